// File: rtl/msk_gf2w_mul_hpc3_pipe_pkg.sv
// Shared constants and helpers for the masked GF(2^W) HPC3 multiplier.
package msk_gf2w_mul_hpc3_pipe_pkg;

  localparam logic [4:0] POLY_GF16  = 5'h13;   // x^4 + x + 1
  localparam logic [8:0] POLY_GF256 = 9'h11B;  // AES x^8 + x^4 + x^3 + x + 1

  // Number of unordered share pairs (i < j); each pair owns one r0 and one r1 field.
  function automatic int unsigned hpc3_rnd_pairs(int unsigned d);
    return d * (d - 1) / 2;
  endfunction

  // Total randomness width: r0 fields in the low half, r1 fields in the high half.
  function automatic int unsigned hpc3_rnd_width(int unsigned w, int unsigned d);
    return w * d * (d - 1);
  endfunction

  // Field index of pair (i, j) with i < j inside one half of rnd.
  function automatic int unsigned hpc3_pair_idx(int unsigned d, int unsigned i, int unsigned j);
    return i * d - i * (i + 1) / 2 + (j - 1 - i);
  endfunction

endpackage

// File: rtl/msk_gf2w_mul_hpc3_pipe_gf2w_mul.sv
// Combinational GF(2^W) multiplier: z = x * y mod POLY (Horner, MSB of y first).
module gf2w_mul #(
  parameter int unsigned W    = 4,
  parameter logic [W:0]  POLY = 5'h13
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] z
);

  logic [W:0] acc;

  // Shift-reduce-accumulate; POLY[W] is set so the reduction always clears acc[W].
  always_comb begin
    acc = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      acc = {acc[W-1:0], 1'b0};
      if (acc[W]) acc = acc ^ POLY;
      if (y[i]) acc[W-1:0] = acc[W-1:0] ^ x;
    end
    z = acc[W-1:0];
  end

endmodule

// File: rtl/msk_gf2w_mul_hpc3_pipe.sv
// Masked GF(2^W) multiplier, HPC3 gadget with d shares and a valid/ready stage.
// Optional macro MSK_GFMUL_FLUSH_EN: clear U/V/A registers on an idle fire_out.
module msk_gf2w_mul_hpc3_pipe
  import msk_gf2w_mul_hpc3_pipe_pkg::*;
#(
  parameter int unsigned d    = 2,
  parameter int unsigned W    = 4,
  parameter logic [8:0]  POLY = 9'(POLY_GF16)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [d*W-1:0]         in_a,
  input  logic [d*W-1:0]         in_b,
  input  logic [W*d*(d-1)-1:0]   rnd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [d*W-1:0]         out_c
);

  localparam int unsigned NP = hpc3_rnd_pairs(d);

  if (d < 2) begin : g_bad_d
    $fatal(1, "msk_gf2w_mul_hpc3_pipe: d must be >= 2");
  end
  if (W < 2 || W > 8) begin : g_bad_w
    $fatal(1, "msk_gf2w_mul_hpc3_pipe: W must be in 2..8");
  end
  if (POLY[W] == 1'b0 || (POLY >> (W + 1)) != 9'd0) begin : g_bad_poly
    $fatal(1, "msk_gf2w_mul_hpc3_pipe: POLY must have degree exactly W");
  end

  logic         accept, fire_out, out_valid_q;
  logic [W-1:0] a_q [d];
  logic [W-1:0] u_q [d][d-1];
  logic [W-1:0] v_q [d][d-1];
  logic [W-1:0] u_d [d][d-1];
  logic [W-1:0] v_d [d][d-1];
  logic [W-1:0] p   [d][d-1];
  logic [W-1:0] acc;

  assign out_valid = out_valid_q;
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign fire_out  = out_valid_q && out_ready;

  for (genvar gi = 0; gi < d; gi++) begin : g_share
    for (genvar gj = 0; gj < d - 1; gj++) begin : g_pair
      localparam int unsigned J  = (gj < gi) ? gj : gj + 1;
      localparam int unsigned LO = (gi < J) ? gi : J;
      localparam int unsigned HI = (gi < J) ? J : gi;
      localparam int unsigned K  = hpc3_pair_idx(d, LO, HI);

      logic [W-1:0] r0, r1, u_y, u_z;
      assign r0 = rnd[W*K +: W];
      assign r1 = rnd[W*(NP+K) +: W];

      // Only the first cross term carries the a_i*b_i product.
      if (gj == 0) begin : g_first
        assign u_y = in_b[W*gi +: W] ^ r0;
      end else begin : g_rest
        assign u_y = r0;
      end

      gf2w_mul #(.W(W), .POLY(POLY[W:0])) u_mul_u (
        .x (in_a[W*gi +: W]),
        .y (u_y),
        .z (u_z)
      );

      assign u_d[gi][gj] = u_z ^ r1;
      assign v_d[gi][gj] = in_b[W*J +: W] ^ r0;

      // Output-side product uses registered operands only.
      gf2w_mul #(.W(W), .POLY(POLY[W:0])) u_mul_o (
        .x (a_q[gi]),
        .y (v_q[gi][gj]),
        .z (p[gi][gj])
      );
    end
  end

  // Handshake state: set on accept, cleared on a fire_out without accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
    end else if (fire_out) begin
      out_valid_q <= 1'b0;
    end
  end

  // Gadget registers: load on accept, otherwise hold (or flush when enabled).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(d); i++) begin
        a_q[i] <= '0;
        for (int j = 0; j < int'(d) - 1; j++) begin
          u_q[i][j] <= '0;
          v_q[i][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < int'(d); i++) begin
        a_q[i] <= in_a[W*i +: W];
        for (int j = 0; j < int'(d) - 1; j++) begin
          u_q[i][j] <= u_d[i][j];
          v_q[i][j] <= v_d[i][j];
        end
      end
`ifdef MSK_GFMUL_FLUSH_EN
    end else if (fire_out) begin
      for (int i = 0; i < int'(d); i++) begin
        a_q[i] <= '0;
        for (int j = 0; j < int'(d) - 1; j++) begin
          u_q[i][j] <= '0;
          v_q[i][j] <= '0;
        end
      end
`endif
    end
  end

  // Per-share output XOR tree, fed from registers only.
  always_comb begin
    out_c = '0;
    acc   = '0;
    for (int i = 0; i < int'(d); i++) begin
      acc = '0;
      for (int j = 0; j < int'(d) - 1; j++) begin
        acc = acc ^ u_q[i][j] ^ p[i][j];
      end
      out_c[W*i +: W] = acc;
    end
  end

endmodule

// File: tb/tb_msk_gf2w_mul_hpc3_pipe.sv
// Self-checking bench: GF(16) d=2 and GF(256) d=3 instances against a polynomial-arithmetic model.
module tb_msk_gf2w_mul_hpc3_pipe;
  import msk_gf2w_mul_hpc3_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // GF(16), d = 2
  logic        v16, ir16, ov16, or16;
  logic [7:0]  a16, b16, r16, oc16;
  // GF(256), d = 3
  logic        v256, ir256, ov256, or256;
  logic [23:0] a256, b256, oc256;
  logic [47:0] r256;

  msk_gf2w_mul_hpc3_pipe #(.d(2), .W(4), .POLY(9'(POLY_GF16))) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .rnd(r16), .out_valid(ov16), .out_ready(or16), .out_c(oc16)
  );

  msk_gf2w_mul_hpc3_pipe #(.d(3), .W(8), .POLY(POLY_GF256)) dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(v256), .in_ready(ir256), .in_a(a256), .in_b(b256),
    .rnd(r256), .out_valid(ov256), .out_ready(or256), .out_c(oc256)
  );

  int n_cmp = 0;
  int n_err = 0;
  int hs16 = 0;
  int hs256 = 0;

  always @(posedge clk) begin
    if (ov16 && or16) hs16 <= hs16 + 1;
    if (ov256 && or256) hs256 <= hs256 + 1;
  end

  // Reference: schoolbook carry-less product, then long division by poly.
  function automatic int gmul(int a, int b, int poly, int w);
    int p;
    p = 0;
    for (int i = 0; i < w; i++) if (((b >> i) & 1) == 1) p = p ^ (a << i);
    for (int bit_i = 2 * w - 2; bit_i >= w; bit_i--)
      if (((p >> bit_i) & 1) == 1) p = p ^ (poly << (bit_i - w));
    return p;
  endfunction

  function automatic logic [7:0] sh16(logic [3:0] v);
    logic [3:0] m;
    m = 4'($urandom);
    return {v ^ m, m};
  endfunction

  function automatic logic [23:0] sh256(logic [7:0] v);
    logic [7:0] m0, m1;
    m0 = 8'($urandom);
    m1 = 8'($urandom);
    return {v ^ m0 ^ m1, m1, m0};
  endfunction

  function automatic int um16(logic [7:0] c);
    return int'(c[3:0] ^ c[7:4]);
  endfunction

  function automatic int um256(logic [23:0] c);
    return int'(c[7:0] ^ c[15:8] ^ c[23:16]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea, eb, prev, hsb;
    logic [7:0]  held16;

    rst_n = 1'b0;
    v16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; r16 = '0;
    v256 = 1'b0; or256 = 1'b1; a256 = '0; b256 = '0; r256 = '0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov16", 32'(ov16), 0);
    chk("rst_ir16", 32'(ir16), 1);
    chk("rst_oc16", 32'(oc16), 0);
    chk("rst_ov256", 32'(ov256), 0);
    chk("rst_ir256", 32'(ir256), 1);
    chk("rst_oc256", 32'(oc256), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ov16", 32'(ov16), 0);

    // GF(16) directed: a=3, b=7 -> 9
    v16 = 1'b1; a16 = {4'h6, 4'h5}; b16 = {4'h5, 4'h2}; r16 = 8'($urandom);
    tick();
    v16 = 1'b0;
    chk("gf16_ov", 32'(ov16), 1);
    chk("gf16_val", 32'(um16(oc16)), 32'h9);
    tick();
    chk("gf16_drain_ov", 32'(ov16), 0);

    // GF(256) d=3 back-to-back
    v256 = 1'b1; a256 = sh256(8'h57); b256 = sh256(8'h83); r256 = 48'({$urandom, $urandom});
    tick();
    chk("gf256_ov1", 32'(ov256), 1);
    chk("gf256_ir1", 32'(ir256), 1);
    chk("gf256_val1", 32'(um256(oc256)), 32'hC1);
    a256 = sh256(8'h57); b256 = sh256(8'h13); r256 = 48'({$urandom, $urandom});
    tick();
    v256 = 1'b0;
    chk("gf256_ov2", 32'(ov256), 1);
    chk("gf256_ir2", 32'(ir256), 1);
    chk("gf256_val2", 32'(um256(oc256)), 32'hFE);
    tick();
    chk("gf256_drain_ov", 32'(ov256), 0);

    // Backpressure: held result stays bit-identical while inputs toggle
    ea = int'($urandom_range(1, 15)); eb = int'($urandom_range(1, 15));
    v16 = 1'b1; or16 = 1'b0; a16 = sh16(4'(ea)); b16 = sh16(4'(eb)); r16 = 8'($urandom);
    tick();
    chk("bp_ov", 32'(ov16), 1);
    chk("bp_ir", 32'(ir16), 0);
    chk("bp_val", 32'(um16(oc16)), 32'(gmul(ea, eb, 'h13, 4)));
    held16 = oc16;
    hsb = hs16;
    for (int k = 0; k < 4; k++) begin
      a16 = 8'($urandom); b16 = 8'($urandom); r16 = 8'($urandom);
      tick();
      chk("bp_hold_ir", 32'(ir16), 0);
      chk("bp_hold_ov", 32'(ov16), 1);
      chk("bp_hold_oc", 32'(oc16), 32'(held16));
    end
    v16 = 1'b0; or16 = 1'b1;
    tick();
    chk("bp_release_ov", 32'(ov16), 0);
    chk("bp_release_hs", 32'(hs16 - hsb), 1);
    tick();
    chk("bp_once_hs", 32'(hs16 - hsb), 1);

    // Exhaustive GF(16): pass 0 random rnd, pass 1 rnd forced to zero
    for (int pass = 0; pass < 2; pass++) begin
      prev = 0;
      for (int n = 0; n <= 256; n++) begin
        if (n > 0) begin
          chk("exh_ov", 32'(ov16), 1);
          chk(pass == 0 ? "exh_val" : "exh_val_r0", 32'(um16(oc16)), 32'(prev));
        end
        if (n < 256) begin
          v16 = 1'b1;
          a16 = sh16(4'(n >> 4));
          b16 = sh16(4'(n & 15));
          r16 = (pass == 0) ? 8'($urandom) : 8'h00;
          prev = gmul(n >> 4, n & 15, 'h13, 4);
        end else begin
          v16 = 1'b0;
        end
        tick();
      end
    end

    // Random GF(256) d=3 stream
    prev = 0;
    for (int n = 0; n <= 64; n++) begin
      if (n > 0) begin
        chk("rnd256_ov", 32'(ov256), 1);
        chk("rnd256_val", 32'(um256(oc256)), 32'(prev));
      end
      if (n < 64) begin
        ea = int'($urandom_range(0, 255)); eb = int'($urandom_range(0, 255));
        v256 = 1'b1; a256 = sh256(8'(ea)); b256 = sh256(8'(eb));
        r256 = 48'({$urandom, $urandom});
        prev = gmul(ea, eb, 'h11B, 8);
      end else begin
        v256 = 1'b0;
      end
      tick();
    end

    // Mid-operation reset drops the pending result without a handshake
    v16 = 1'b1; or16 = 1'b0; a16 = sh16(4'h7); b16 = sh16(4'hB); r16 = 8'($urandom);
    tick();
    chk("mrst_pending_ov", 32'(ov16), 1);
    hsb = hs16;
    v16 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", 32'(ov16), 0);
    chk("mrst_ir", 32'(ir16), 1);
    chk("mrst_oc", 32'(oc16), 0);
    tick();
    rst_n = 1'b1; or16 = 1'b1;
    tick();
    chk("mrst_after_ov", 32'(ov16), 0);
    chk("mrst_no_hs", 32'(hs16 - hsb), 0);

    // Flush behaviour after an idle fire_out
    ea = int'($urandom_range(1, 15)); eb = int'($urandom_range(1, 15));
    v16 = 1'b1; or16 = 1'b1; a16 = sh16(4'(ea)); b16 = sh16(4'(eb)); r16 = 8'($urandom);
    tick();
    v16 = 1'b0;
    chk("flush_ov", 32'(ov16), 1);
    chk("flush_val", 32'(um16(oc16)), 32'(gmul(ea, eb, 'h13, 4)));
    held16 = oc16;
    tick();
    chk("flush_idle_ov", 32'(ov16), 0);
`ifdef MSK_GFMUL_FLUSH_EN
    chk("flush_oc_cleared", 32'(oc16), 0);
`else
    chk("flush_oc_retained", 32'(oc16), 32'(held16));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
